riscv_alu_muldiv: RTL
=====================

Name: riscv_alu_muldiv

Overview:
- Parametrised, handshaked successor to the combinational RV32 ALU.
- Executes base integer ops with a 1-cycle registered latency.
- Executes RV M-extension multiply/divide/remainder iteratively over XLEN cycles.
- Sits in the EX stage. The pipeline stalls on in_ready/out_valid instead of assuming single-cycle results.

Parameters:
- XLEN, 32: operand/result width. Must be a power of two, ≥8.
- SHW, $clog2(XLEN): shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- op  in  5  operation select (encoding below).
- src_a  in  XLEN  operand A.
- src_b  in  XLEN  operand B.
- kill  in  1  abort any in-flight or held operation.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  registered result.
- zero  out  1  result == 0.
- negative  out  1  result[XLEN-1].
- overflow  out  1  signed overflow (ADD/SUB only).
- carryout  out  1  carry out of the adder (ADD/SUB only).
- busy  out  1  iterative operation in progress.

Behaviour:
- Reset: rst asserted drives state=IDLE, result=0, out_valid=0, overflow=0, carryout=0, busy=0, in_ready=1 immediately (asynchronous). zero=1 and negative=0 follow from result=0.
- Base op encoding:
  - 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR.
  - 5 SRA, 6 SLL, 7 SRL (shift by src_b[SHW-1:0] only).
  - 8 SLT (signed), 9 SLTU (unsigned), 10 NOR. SLT/SLTU result is 0 or 1, zero-extended.
- M op encoding: 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
- Any other op: treated as a base op with result=0, flags=0.
- Accept rule: an op is accepted when in_valid && in_ready on a rising edge. Operands and op are captured at that edge; later input changes are ignored.
- in_ready:
  - 1 in IDLE.
  - 1 in DONE when out_ready=1 (back-to-back issue allowed).
  - 0 in BUSY, and 0 in DONE when out_ready=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> DONE on accepting a base op (out_valid rises the next cycle; latency 1).
  - IDLE -> BUSY on accepting an M op. Iteration counter is loaded with XLEN.
  - BUSY decrements the counter once per cycle. At count 0 it loads result and flags and goes to DONE. Total latency from the accept edge to out_valid is XLEN+1 cycles, fixed, including special cases.
  - DONE holds result, flags and out_valid stable until out_ready=1.
  - DONE, on out_ready=1: if a new op is accepted in the same cycle, take the IDLE transition for it; otherwise go to IDLE with out_valid=0.
- Multiply:
  - Radix-2 shift-add on magnitudes, 2*XLEN-bit product; sign fixed up at completion.
  - MUL returns the low XLEN bits.
  - MULH/MULHSU/MULHU return the high XLEN bits. MULH treats both operands signed; MULHSU treats A signed, B unsigned; MULHU treats both unsigned.
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign = sign A xor sign B; remainder sign = sign A (signed ops only).
- Divide by zero:
  - DIV/DIVU quotient = all ones.
  - REM/REMU remainder = src_a.
- Signed divide overflow (A = -2^(XLEN-1), B = -1): DIV quotient = src_a, REM remainder = 0.
- Flags:
  - zero and negative are derived combinationally from the result register.
  - ADD/SUB: carryout = carry out of the XLEN-bit add of A + B, or of A + ~B + 1 for SUB (so SUB carryout=1 iff A ≥ B unsigned). overflow = signed overflow of that add.
  - All other ops: overflow=0, carryout=0.
- busy = (state==BUSY).
- kill has priority over all other inputs: the next edge forces IDLE and out_valid=0. No op is accepted in a kill cycle. The result register keeps its old value.
- Reset asserted mid-iteration discards the operation; no out_valid for it.

Test Plan:
- Reset, then ADD 0x7FFFFFFF+0x00000001 -> one cycle after accept: result=0x80000000, overflow=1, carryout=0, negative=1. SUB 5-5 -> result=0, zero=1, carryout=1.
- SRA 0x80000000 by src_b=0x00000024 (only shift amount 4 used) -> 0xF8000000. SLTU 1 vs 0xFFFFFFFF -> 1. SLT same operands -> 0.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000, MULHU same -> 0xFFFFFFFE, MUL same -> 0x00000001. out_valid exactly 33 cycles after accept; in_ready=0 and busy=1 throughout.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same -> 0. DIVU 7/0 -> 0xFFFFFFFF. REMU 7/0 -> 7. DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF.
- Backpressure: hold out_ready=0 for 5 cycles after DONE -> result stable, in_ready=0. Raise out_ready with in_valid=1 (AND) -> new result next cycle, no bubble.
- Assert kill at cycle 10 of a DIVU -> IDLE, out_valid never rises. Assert rst mid-MUL -> all outputs at reset values immediately.

Source files
------------

// File: rtl/riscv_alu_muldiv.sv
// riscv_alu_muldiv: handshaked RV32 EX-stage ALU with an iterative M-extension unit.
// Base integer ops produce a registered result in the cycle after acceptance.
// MUL/MULH/MULHSU/MULHU use radix-2 shift-add, and DIV/DIVU/REM/REMU use restoring
// division. Both work on operand magnitudes over XLEN iterations, and the sign is
// fixed up when the result is loaded.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready        operation request handshake; op/src_a/src_b captured on accept
//   kill                     abort any in-flight or held operation (highest priority)
//   out_valid/out_ready      result handshake; result and flags held while out_ready=0
//   result, zero, negative   registered result and flags derived from it
//   overflow, carryout       ADD/SUB adder flags, 0 for every other op
//   busy                     iterative operation in progress
module riscv_alu_muldiv #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            negative,
  output logic            overflow,
  output logic            carryout,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [SHW:0]          r_cnt;
  logic [XLEN-1:0]       r_result;
  logic                  r_ov, r_co;
  logic [XLEN-1:0]       r_hi, r_lo, r_mb;
  logic                  r_div, r_neg_q, r_neg_r, r_b_zero, r_rem_sel, r_mulhi;

  logic                  w_is_m, w_accept;
  logic                  w_sa_signed, w_sb_signed, w_neg_a, w_neg_b;
  logic [XLEN-1:0]       w_mag_a, w_mag_b;
  logic [XLEN+1:0]       w_base;
  logic [XLEN:0]         w_msum, w_dshl, w_ddif;
  logic                  w_dge;
  logic [2*XLEN-1:0]     w_prod, w_prod_fix;
  logic [XLEN-1:0]       w_quo, w_rem, w_m_res;

  // Base ALU: returns {overflow, carryout, result}.
  function automatic logic [XLEN+1:0] alu_base(input logic [4:0] f_op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN:0]   sum;
    logic [XLEN-1:0] res;
    logic            ov, co;
    logic [SHW-1:0]  sh;
    sh  = b[SHW-1:0];
    sum = '0;
    res = '0;
    ov  = 1'b0;
    co  = 1'b0;
    case (f_op)
      5'd0: res = a & b;
      5'd1: res = a | b;
      5'd2: begin
        sum = {1'b0, a} + {1'b0, b};
        res = sum[XLEN-1:0];
        co  = sum[XLEN];
        ov  = (a[XLEN-1] == b[XLEN-1]) && (res[XLEN-1] != a[XLEN-1]);
      end
      5'd3: begin
        // A + ~B + 1, so carryout means "no borrow" (A >= B unsigned).
        sum = {1'b0, a} + {1'b0, ~b} + (XLEN+1)'(1);
        res = sum[XLEN-1:0];
        co  = sum[XLEN];
        ov  = (a[XLEN-1] != b[XLEN-1]) && (res[XLEN-1] != a[XLEN-1]);
      end
      5'd4:  res = a ^ b;
      5'd5:  res = $unsigned($signed(a) >>> sh);
      5'd6:  res = a << sh;
      5'd7:  res = a >> sh;
      5'd8:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      5'd9:  res = {{(XLEN-1){1'b0}}, (a < b)};
      5'd10: res = ~(a | b);
      default: res = '0;
    endcase
    return {ov, co, res};
  endfunction

  assign w_is_m   = (op[4:3] == 2'b10);
  assign in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept = in_valid && in_ready && !kill;
  assign w_base   = alu_base(op, src_a, src_b);

  // Operand signedness: op[2] selects divide (op[0]=1 unsigned), otherwise
  // op[1:0] = MUL/MULH (both signed), MULHSU (A only), MULHU (neither).
  assign w_sa_signed = op[2] ? !op[0] : (op[1:0] != 2'b11);
  assign w_sb_signed = op[2] ? !op[0] : !op[1];
  assign w_neg_a     = w_sa_signed && src_a[XLEN-1];
  assign w_neg_b     = w_sb_signed && src_b[XLEN-1];
  assign w_mag_a     = w_neg_a ? (~src_a + XLEN'(1)) : src_a;
  assign w_mag_b     = w_neg_b ? (~src_b + XLEN'(1)) : src_b;

  // One iteration step. Multiply: {hi,lo} holds partial product and multiplier.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  // The divide compare is a full-width >= so a zero divisor simply shifts the
  // dividend into hi, leaving remainder = |A| and quotient = all ones.
  assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mb} : '0);
  assign w_dshl = {r_hi, r_lo[XLEN-1]};
  assign w_dge  = (w_dshl >= {1'b0, r_mb});
  assign w_ddif = w_dshl - {1'b0, r_mb};

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg_q ? (~w_prod + (2*XLEN)'(1)) : w_prod;
  assign w_quo      = r_neg_q ? (~r_lo + XLEN'(1)) : r_lo;
  assign w_rem      = r_neg_r ? (~r_hi + XLEN'(1)) : r_hi;

  always_comb begin
    w_m_res = '0;
    if (r_div) begin
      if (r_rem_sel)     w_m_res = w_rem;
      else if (r_b_zero) w_m_res = '1;
      else               w_m_res = w_quo;
    end else begin
      w_m_res = r_mulhi ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_is_m ? S_BUSY : S_DONE;
      S_BUSY: if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) begin
        if (w_accept) w_state_nxt = w_is_m ? S_BUSY : S_DONE;
        else          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (kill) w_state_nxt = S_IDLE;
  end

  // Control, result and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_result <= '0;
      r_ov     <= 1'b0;
      r_co     <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= (SHW+1)'(XLEN);
      if (!w_is_m) {r_ov, r_co, r_result} <= w_base;
    end else if ((r_state == S_BUSY) && !kill) begin
      if (r_cnt == '0) begin
        r_result <= w_m_res;
        r_ov     <= 1'b0;
        r_co     <= 1'b0;
      end else begin
        r_cnt <= r_cnt - (SHW+1)'(1);
      end
    end
  end

  // Iteration datapath, unreset: always reloaded on accept before use.
  always_ff @(posedge clk) begin
    if (w_accept && w_is_m) begin
      r_hi      <= '0;
      r_lo      <= w_mag_a;
      r_mb      <= w_mag_b;
      r_div     <= op[2];
      r_neg_q   <= w_neg_a ^ w_neg_b;
      r_neg_r   <= w_neg_a;
      r_b_zero  <= (src_b == '0);
      r_rem_sel <= op[1];
      r_mulhi   <= (op[1:0] != 2'b00);
    end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
      if (r_div) begin
        r_hi <= w_dge ? w_ddif[XLEN-1:0] : w_dshl[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_dge};
      end else begin
        r_hi <= w_msum[XLEN:1];
        r_lo <= {w_msum[0], r_lo[XLEN-1:1]};
      end
    end
  end

  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_BUSY);
  assign result    = r_result;
  assign zero      = (r_result == '0);
  assign negative  = r_result[XLEN-1];
  assign overflow  = r_ov;
  assign carryout  = r_co;

endmodule
